// File: rtl/gray_conv_pkg.sv
// Shared types, constants and code conversion functions for the Gray/binary converter.
// The functions work on zero-extended codes, so one definition serves every width up to MAX_WIDTH.
package gray_conv_pkg;

    typedef enum logic {
        MODE_G2B = 1'b0,
        MODE_B2G = 1'b1
    } conv_mode_e;

    localparam int ERR_CNT_W = 8;
    localparam int MAX_WIDTH = 32;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero bits above the real width leave the prefix XOR unchanged, so slicing afterwards is exact.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_conv_if.sv
// Valid/ready stream bundle of the Gray/binary converter: input beat, output beat and error status.
// master = the surrounding system, slave = the converter.
interface gray_conv_if
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    conv_mode_e           in_mode;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    conv_mode_e           out_mode;
    logic [WIDTH-1:0]     out_data;
    logic                 out_adj_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data, out_adj_err, err_count
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data, out_adj_err, err_count
    );
endinterface

// File: rtl/gray_conv_stage.sv
// One valid/ready register slice; the payload packs {err, mode, data} (err only when checking is built in).
// Accepts whenever it is empty or its content leaves in the same cycle.
module gray_conv_stage #(
    parameter int PW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_pay,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_pay
);

    assign in_ready = !out_valid || out_ready;

    // NOTE: non-blocking assignments let every slice sample its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pay   <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_pay <= in_pay;
            end
        end
    end

endmodule

// File: rtl/gray_conv_pipe.sv
// Pipelined Gray<->binary converter, direction chosen per beat, STAGES cycles of latency.
// Define GRAY_ADJ_CHECK_EN to build the Gray adjacency checker and its saturating error counter.
module gray_conv_pipe
    import gray_conv_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    gray_conv_if.slave bus
);

`ifdef GRAY_ADJ_CHECK_EN
    localparam int PW = WIDTH + 2;
`else
    localparam int PW = WIDTH + 1;
`endif

    logic [PW-1:0]    pay [0:STAGES];
    logic             vld [0:STAGES];
    logic             rdy [0:STAGES];
    logic [WIDTH-1:0] conv;

    assign conv = (bus.in_mode == MODE_B2G) ? WIDTH'(bin2gray(MAX_WIDTH'(bus.in_data)))
                                            : WIDTH'(gray2bin(MAX_WIDTH'(bus.in_data)));

    assign vld[0]      = bus.in_valid;
    assign bus.in_ready = rdy[0];
    assign rdy[STAGES] = bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        gray_conv_stage #(.PW(PW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld[k]),
            .in_ready  (rdy[k]),
            .in_pay    (pay[k]),
            .out_valid (vld[k+1]),
            .out_ready (rdy[k+1]),
            .out_pay   (pay[k+1])
        );
    end

    assign bus.out_valid = vld[STAGES];
    assign bus.out_data  = pay[STAGES][WIDTH-1:0];
    assign bus.out_mode  = conv_mode_e'(pay[STAGES][WIDTH]);

`ifdef GRAY_ADJ_CHECK_EN
    logic [WIDTH-1:0]     prev_gray;
    logic                 prev_vld;
    logic                 in_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    // Only Gray inputs take part in the history; binary beats pass straight through.
    assign in_err = (bus.in_mode == MODE_G2B) && prev_vld
                    && ($countones(prev_gray ^ bus.in_data) > 1);
    assign pay[0] = {in_err, bus.in_mode, conv};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray <= '0;
            prev_vld  <= 1'b0;
        end else if (bus.in_valid && rdy[0] && bus.in_mode == MODE_G2B) begin
            prev_gray <= bus.in_data;
            prev_vld  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (vld[STAGES] && bus.out_ready && pay[STAGES][WIDTH+1] && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.out_adj_err = pay[STAGES][WIDTH+1];
    assign bus.err_count   = err_cnt;
`else
    assign pay[0]          = {bus.in_mode, conv};
    assign bus.out_adj_err = 1'b0;
    assign bus.err_count   = '0;
`endif

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Self-checking bench for gray_conv_pipe: directed steps on a 4-bit/2-stage instance, random traffic on 8-bit/4-stage.
// Expected beats come from an arithmetic reference model and an in-flight queue; adjacency checks follow GRAY_ADJ_CHECK_EN.
module tb_gray_conv_pipe;
    import gray_conv_pkg::*;

    localparam int WA = 4;
    localparam int SA = 2;
    localparam int WB = 8;
    localparam int SB = 4;
`ifdef GRAY_ADJ_CHECK_EN
    localparam bit ADJ_EN = 1'b1;
`else
    localparam bit ADJ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_conv_if #(.WIDTH(WA)) ia ();
    gray_conv_if #(.WIDTH(WB)) ib ();

    gray_conv_pipe #(.WIDTH(WA), .STAGES(SA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    gray_conv_pipe #(.WIDTH(WB), .STAGES(SB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    typedef struct {
        logic [31:0] data;
        logic        mode;
        logic        err;
        int          cyc;
    } beat_t;

    beat_t       expq [2][$];
    logic [31:0] gotd [2][$];
    logic        gote [2][$];
    int          cyc [2];
    logic [31:0] prev_g [2];
    bit          prev_v [2];
    int          ecnt_m [2];
    bit          stalled [2];
    logic [31:0] last_d [2];
    bit          lat_chk [2];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Binary value of a Gray code is the XOR of all its right shifts.
    function automatic logic [31:0] ref_g2b(input logic [31:0] g);
        logic [31:0] b = '0;
        for (int s = 0; s < 32; s++) b ^= g >> s;
        return b;
    endfunction

    function automatic logic [31:0] ref_b2g(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic reset_model();
        for (int id = 0; id < 2; id++) begin
            expq[id].delete();
            gotd[id].delete();
            gote[id].delete();
            prev_v[id]  = 1'b0;
            ecnt_m[id]  = 0;
            stalled[id] = 1'b0;
        end
    endtask

    task automatic score(input int id, input logic vin, input logic m, input logic [31:0] d,
                         input logic ordy, input logic iready, input logic ovalid,
                         input logic [31:0] odata, input logic omode, input logic oerr,
                         input logic [31:0] ecnt, output logic acc);
        string       p = (id == 0) ? "A" : "B";
        int          w = (id == 0) ? WA : WB;
        int          stg = (id == 0) ? SA : SB;
        logic [31:0] mask = (32'h1 << w) - 1;
        logic [31:0] dm = d & mask;
        beat_t       e;
        cyc[id]++;
        check({p, "_in_ready"}, iready, (ordy || expq[id].size() < stg) ? 1 : 0);
        check({p, "_err_count"}, ecnt, ecnt_m[id]);
        if (expq[id].size() == 0) check({p, "_out_valid_idle"}, ovalid, 0);
        if (stalled[id]) begin
            check({p, "_stall_valid"}, ovalid, 1);
            check({p, "_stall_data"}, odata, last_d[id]);
        end
        if (ovalid && ordy && expq[id].size() != 0) begin
            e = expq[id].pop_front();
            check({p, "_out_data"}, odata, e.data);
            check({p, "_out_mode"}, omode, e.mode);
            check({p, "_out_adj_err"}, oerr, e.err);
            if (lat_chk[id]) check({p, "_latency"}, cyc[id] - e.cyc, stg);
            gotd[id].push_back(odata);
            gote[id].push_back(oerr);
            if (e.err && ecnt_m[id] < 255) ecnt_m[id]++;
        end
        stalled[id] = ovalid && !ordy;
        last_d[id]  = odata;
        acc = vin && iready;
        if (acc) begin
            e.data = m ? ref_b2g(dm) : ref_g2b(dm);
            e.mode = m;
            e.err  = ADJ_EN && !m && prev_v[id] && ($countones(dm ^ prev_g[id]) > 1);
            e.cyc  = cyc[id];
            expq[id].push_back(e);
            if (!m) begin
                prev_g[id] = dm;
                prev_v[id] = 1'b1;
            end
        end
    endtask

    task automatic cycle_a(input logic v, input logic m, input logic [31:0] d, input logic ordy,
                           output logic acc);
        @(negedge clk);
        ia.in_valid  = v;
        ia.in_mode   = conv_mode_e'(m);
        ia.in_data   = d[WA-1:0];
        ia.out_ready = ordy;
        #1;
        score(0, v, m, d, ordy, ia.in_ready, ia.out_valid, 32'(ia.out_data), ia.out_mode,
              ia.out_adj_err, 32'(ia.err_count), acc);
    endtask

    task automatic cycle_b(input logic v, input logic m, input logic [31:0] d, input logic ordy,
                           output logic acc);
        @(negedge clk);
        ib.in_valid  = v;
        ib.in_mode   = conv_mode_e'(m);
        ib.in_data   = d[WB-1:0];
        ib.out_ready = ordy;
        #1;
        score(1, v, m, d, ordy, ib.in_ready, ib.out_valid, 32'(ib.out_data), ib.out_mode,
              ib.out_adj_err, 32'(ib.err_count), acc);
    endtask

    task automatic drain_a();
        logic acc;
        for (int k = 0; k < 20 && expq[0].size() != 0; k++) cycle_a(0, 0, 0, 1, acc);
        check("A_drained", expq[0].size(), 0);
    endtask

    task automatic drain_b();
        logic acc;
        for (int k = 0; k < 200 && expq[1].size() != 0; k++) cycle_b(0, 0, 0, 1, acc);
        check("B_drained", expq[1].size(), 0);
    endtask

    logic [3:0] t1_in  [6] = '{4'b1011, 4'b1111, 4'b1000, 4'b1001, 4'b0011, 4'b1101};
    logic [3:0] t1_out [6] = '{4'b1101, 4'b1010, 4'b1111, 4'b1110, 4'b0010, 4'b1001};
    logic [3:0] t3_in  [4] = '{4'b0001, 4'b0110, 4'b1100, 4'b1011};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        acc;
        int          idx;
        int          nacc;
        logic [31:0] d;
        logic [31:0] last_b;
        logic        v, m, r;

        ia.in_valid = 0; ia.in_mode = MODE_G2B; ia.in_data = '0; ia.out_ready = 0;
        ib.in_valid = 0; ib.in_mode = MODE_G2B; ib.in_data = '0; ib.out_ready = 0;
        reset_model();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", ia.out_valid, 0);
        check("rst_out_data", 32'(ia.out_data), 0);
        check("rst_out_mode", ia.out_mode, 0);
        check("rst_out_adj_err", ia.out_adj_err, 0);
        check("rst_err_count", 32'(ia.err_count), 0);
        check("rst_b_out_valid", ib.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back Gray->binary stream, exact latency and one beat per cycle
        lat_chk[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle_a(1, 0, 32'(t1_in[i]), 1, acc);
            check("t1_accept", acc, 1);
        end
        drain_a();
        lat_chk[0] = 1'b0;
        check("t1_count", gotd[0].size(), 6);
        for (int i = 0; i < 6 && i < gotd[0].size(); i++) check("t1_value", gotd[0][i], 32'(t1_out[i]));

        // Binary->Gray single beat, then a mixed-mode stream
        gotd[0].delete();
        cycle_a(1, 1, 32'b1101, 1, acc);
        drain_a();
        if (gotd[0].size() != 0) check("t2_b2g", gotd[0][0], 32'b1011);
        else check("t2_b2g_present", gotd[0].size(), 1);
        for (int i = 0; i < 12; i++) cycle_a(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 1, acc);
        drain_a();

        // Backpressure: 5 stalled cycles with 4 beats offered
        gotd[0].delete();
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            cycle_a(idx < 4, 0, (idx < 4) ? 32'(t3_in[idx]) : 0, 0, acc);
            if (acc) idx++;
        end
        check("t3_accepted_while_stalled", idx, 2);
        for (int k = 0; k < 20 && (idx < 4 || expq[0].size() != 0); k++) begin
            cycle_a(idx < 4, 0, (idx < 4) ? 32'(t3_in[idx]) : 0, 1, acc);
            if (acc) idx++;
        end
        check("t3_all_accepted", idx, 4);
        check("t3_all_delivered", gotd[0].size(), 4);
        for (int i = 0; i < 4 && i < gotd[0].size(); i++) check("t3_value", gotd[0][i], ref_g2b(32'(t3_in[i])));

        // Adjacency history with an intervening binary->Gray beat
        @(negedge clk); rst_n = 1'b0; reset_model();
        @(negedge clk); rst_n = 1'b1;
        cycle_a(1, 0, 32'b1011, 1, acc);
        cycle_a(1, 1, 32'b0110, 1, acc);
        cycle_a(1, 0, 32'b1111, 1, acc);
        cycle_a(1, 0, 32'b1000, 1, acc);
        drain_a();
        cycle_a(0, 0, 0, 1, acc);
        check("t4_err_count", 32'(ia.err_count), ADJ_EN ? 1 : 0);
        if (gote[0].size() == 4) begin
            check("t4_adjacent_ok", gote[0][2], 0);
            check("t4_jump_flagged", gote[0][3], ADJ_EN);
        end else check("t4_beats", gote[0].size(), 4);

        // Reset while stalled with the pipe full
        for (int c = 0; c < 3; c++) cycle_a(1, 0, 32'b0000, 0, acc);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", ia.out_valid, 0);
        check("t5_out_data", 32'(ia.out_data), 0);
        check("t5_out_adj_err", ia.out_adj_err, 0);
        check("t5_err_count", 32'(ia.err_count), 0);
        ia.in_valid = 0;
        reset_model();
        @(negedge clk); rst_n = 1'b1;
        cycle_a(1, 0, 32'b1111, 1, acc);
        cycle_a(1, 0, 32'b0000, 1, acc);
        drain_a();
        if (gote[0].size() == 2) begin
            check("t5_first_not_flagged", gote[0][0], 0);
            check("t5_second_flagged", gote[0][1], ADJ_EN);
        end else check("t5_beats", gote[0].size(), 2);

        // Wide/deep instance: sustained throughput
        lat_chk[1] = 1'b1;
        nacc = 0;
        last_b = '0;
        for (int c = 0; c < 200; c++) begin
            d = 32'($urandom_range(0, 255));
            cycle_b(1, 1'($urandom_range(0, 1)), d, 1, acc);
            if (acc) nacc++;
        end
        check("t6_sustain", nacc, 200);
        drain_b();
        lat_chk[1] = 1'b0;

        // Random 1000-beat stream with random backpressure
        nacc = 0;
        for (int k = 0; k < 6000 && nacc < 1000; k++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) != 0) d = 32'($urandom_range(0, 255));
            else d = last_b ^ (32'h1 << $urandom_range(0, 7));
            cycle_b(v, m, d, r, acc);
            if (acc) begin
                nacc++;
                last_b = d & 32'hff;
            end
        end
        check("t6_random_beats", nacc, 1000);
        drain_b();

        // Forced violations drive the counter into saturation
        for (int c = 0; c < 300; c++) cycle_b(1, 0, (c % 2 == 0) ? 32'h00 : 32'hff, 1, acc);
        drain_b();
        cycle_b(0, 0, 0, 1, acc);
        check("t6_err_saturated", 32'(ib.err_count), ADJ_EN ? 255 : 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gray_conv_pipe.md
# gray_conv_pipe

Parametrised, pipelined Gray/binary code converter with valid/ready handshakes on both sides. Each beat selects its own direction: Gray→binary or binary→Gray. Optionally, the block checks that successive Gray inputs differ in at most one bit. It sits on pointer and encoder-sampling paths, such as async FIFO pointer decode and rotary/absolute encoder capture, and replaces the fixed 4-bit combinational Gray-to-binary converter.

## Interface
Parameters:
- WIDTH, 4, code width in bits (2..32)
- STAGES, 2, pipeline register stages (1..4); this equals the latency in cycles

Ports (clock and reset are decided: one clock; reset is asynchronous and active-low):
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat
- in_mode  in  1  0 = Gray→binary, 1 = binary→Gray
- in_data  in  WIDTH  code to convert
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts the beat
- out_mode  out  1  mode the beat was issued with
- out_data  out  WIDTH  converted code
- out_adj_err  out  1  beat violated Gray adjacency (GRAY_ADJ_CHECK_EN only; otherwise tied 0)
- err_count  out  8  saturating count of adjacency violations (GRAY_ADJ_CHECK_EN only; otherwise tied 0)

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Conversion is combinational on in_data and is registered into stage 0. Stages 1..STAGES-1 are pure carry registers for {data, mode, err}.
- Gray→binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
- Binary→Gray: g = b ^ (b >> 1).
- Each stage k has a valid bit v[k]. ready[k] = !v[k] || ready[k+1], with ready[STAGES] = out_ready. in_ready = ready[0].
  - Stage k loads when ready[k] is high.
  - Stage k clears v[k] when its contents move on and no new beat arrives.
- No bubbles: with out_ready held at 1, one beat per cycle sustains.
- Backpressure: when out_ready = 0 and all stages are valid, in_ready = 0 in the same cycle.
  - Stalled data is held stable.
  - out_valid must not drop until the beat transfers.
- Adjacency check (macro on):
  - prev_gray and prev_vld are updated only on an accepted mode-0 beat.
  - Mode-1 beats neither update nor check the history.
  - A mode-0 beat with prev_vld = 1 and popcount(prev_gray ^ in_data) > 1 sets its err bit.
  - The first mode-0 beat after reset is never flagged.
  - Equal consecutive codes (popcount 0) are legal.
  - err_count increments when a flagged beat transfers out, and saturates at 255.
- Reset (asserted at any time, including mid-stall): all v[k] = 0, in_ready = 1 on the cycle after reset release, out_valid = 0, out_data = 0, out_mode = 0, out_adj_err = 0, err_count = 0, prev_vld = 0. In-flight beats are discarded.

## Timing
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, i.e. it is presented for transfer at edge N+STAGES.
- in_ready depends combinationally on out_ready; there is no other in→out combinational path.
- On a simultaneous in-transfer and out-transfer with the pipe full, the pipe shifts and stays full.

## Configuration
- GRAY_ADJ_CHECK_EN defined: adjacency checker, prev_gray/prev_vld, the per-stage err bit and err_count are present.
- GRAY_ADJ_CHECK_EN undefined: that logic is absent; out_adj_err and err_count are constant 0. Data, handshake and latency are identical.

## Structure
- Shared package gray_conv_pkg holds:
  - the conv_mode_e typedef (MODE_G2B = 0, MODE_B2G = 1)
  - ERR_CNT_W = 8
  - conversion functions gray2bin/bin2gray, parametrised by width
- One natural sub-module: gray_conv_stage, a single valid/ready register slice carrying {data, mode, err}. It is instantiated STAGES times by a generate loop.

## Test plan
- WIDTH=4, STAGES=2, mode 0, inputs 1011, 1111, 1000, 1001, 0011, 1101 back-to-back with out_ready = 1 → outputs 1101, 1010, 1111, 1110, 0010, 1001, first at 2 cycles, one per cycle.
- Mode 1, input 1101 → 1011. Mixed mode 0/1 stream → each out_mode matches its input beat.
- Hold out_ready = 0 for 5 cycles while driving 4 beats → in_ready falls after 2 accepted, out_data stable, no loss or duplication after release.
- Macro on, mode 0: 1011 → 1111 (1 bit, no err) → 1000 (3 bits) → out_adj_err = 1 on the third beat, err_count = 1. An intervening mode-1 beat does not disturb the history.
- Assert rst_n low mid-stall with the pipe full → out_valid = 0 and err_count = 0 immediately. After release, the first mode-0 beat is not flagged.
- WIDTH=8, STAGES=4, random 1000-beat stream with random out_ready → matches the reference model and sustains 1 beat/cycle when out_ready = 1; err_count saturates at 255 under forced violations.
